// File: rtl/bus_handshake_pkg.sv
// Shared state type and counter sizing for the bus handshake master.
// The timeout logic that uses cnt_width is built only with MASTER_TIMEOUT_EN.
package bus_handshake_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    // Bits needed to hold the values 0 .. n-1, never fewer than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_resp_timer.sv
// Response window timer and retry counter for bus_handshake_master.
// Instantiated only when MASTER_TIMEOUT_EN is defined.
module hs_resp_timer
    import bus_handshake_pkg::*;
#(
    parameter int RESP_TIMEOUT = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic retry_inc,
    input  logic retry_clr,
    output logic expire,
    output logic retries_left
);

    localparam int TW = cnt_width(RESP_TIMEOUT);
    localparam int RW = cnt_width(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RESP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;

    // Down-counter loaded on entry to the wait: terminal count is the last cycle of the window.
    always_comb begin
        timer_d = timer_q;
        if (start) begin
            timer_d = TIMER_LOAD;
        end else if (run && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end

        retry_d = retry_q;
        if (retry_clr) begin
            retry_d = '0;
        end else if (retry_inc) begin
            retry_d = retry_q + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    assign expire       = run && (timer_q == '0);
    assign retries_left = (retry_q < RETRY_MAX);

endmodule

// File: rtl/bus_handshake_master.sv
// Bus handshake master: sends each new source word with valid/ready, then waits for a response.
// Define MASTER_TIMEOUT_EN to add response timeout, retransmission and the sticky fail flag.
module bus_handshake_master
    import bus_handshake_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int RESP_TIMEOUT = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ready,
    input  logic                  response,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  busy,
    output logic                  fail
);

    // state     | meaning
    // IDLE      | waiting for data to differ from the last committed word
    // SEND      | valid high, dout held until the slave takes it with ready
    // WAIT_RESP | word accepted, waiting for the slave response pulse

    if (RESP_TIMEOUT < 1 || MAX_RETRY < 0) begin : g_cfg_check
        $error("bus_handshake_master: RESP_TIMEOUT must be >= 1 and MAX_RETRY >= 0");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] last_sent_q, last_sent_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  fail_q, fail_d;

`ifdef MASTER_TIMEOUT_EN
    logic timer_start, in_wait, expire, retries_left, retry_inc, retry_clr;

    assign in_wait = (state_q == WAIT_RESP);

    hs_resp_timer #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) u_resp_timer (
        .clk          (clk),
        .reset        (reset),
        .start        (timer_start),
        .run          (in_wait),
        .retry_inc    (retry_inc),
        .retry_clr    (retry_clr),
        .expire       (expire),
        .retries_left (retries_left)
    );
`endif

    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        fail_d      = fail_q;
        last_sent_d = last_sent_q;
`ifdef MASTER_TIMEOUT_EN
        timer_start = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (data != last_sent_q) begin
                    dout_d  = data;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_RESP;
`ifdef MASTER_TIMEOUT_EN
                    timer_start = 1'b1;
`endif
                end
            end
            WAIT_RESP: begin
                // A response on the timeout edge still counts as success.
                if (response) begin
                    last_sent_d = dout_q;
                    fail_d      = 1'b0;
                    state_d     = IDLE;
`ifdef MASTER_TIMEOUT_EN
                    retry_clr   = 1'b1;
                end else if (expire) begin
                    if (retries_left) begin
                        retry_inc = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = SEND;
                    end else begin
                        fail_d      = 1'b1;
                        last_sent_d = dout_q;
                        retry_clr   = 1'b1;
                        state_d     = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            last_sent_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            last_sent_q <= last_sent_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign fail  = fail_q;

endmodule

// File: tb/tb_bus_handshake_master.sv
// Self-checking bench for bus_handshake_master: directed scenarios then randomized transfers
// checked against a transfer-level model; timeout scenarios follow MASTER_TIMEOUT_EN.
module tb_bus_handshake_master;

    localparam int DW = 32;
    localparam int RT = 16;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data;
    logic          ready;
    logic          response;
    logic [DW-1:0] dout;
    logic          valid;
    logic          busy;
    logic          fail;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: word most recently acknowledged or dropped; a transfer starts when data differs.
    logic [DW-1:0] m_last_sent;

    bus_handshake_master #(
        .DATA_WIDTH   (DW),
        .RESP_TIMEOUT (RT),
        .MAX_RETRY    (MR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .ready    (ready),
        .response (response),
        .dout     (dout),
        .valid    (valid),
        .busy     (busy),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept the word currently in SEND and acknowledge it after resp_delay idle wait cycles.
    task automatic accept_and_ack(input string tag, input int resp_delay);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_bit({tag, "_valid_after_ready"}, valid, 1'b0);
        check_bit({tag, "_busy_after_ready"}, busy, 1'b1);
        for (int k = 0; k < resp_delay; k++) begin
            step();
            check_bit({tag, "_valid_wait"}, valid, 1'b0);
        end
        response = 1'b1;
        step();
        response = 1'b0;
        check_bit({tag, "_busy_after_resp"}, busy, 1'b0);
        check_bit({tag, "_fail_after_resp"}, fail, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w;
        int            sel;
        int            r;
        int            d;

        reset    = 1'b1;
        data     = 'x;
        ready    = 1'b0;
        response = 1'b0;

        // Reset held 10 cycles with an unknown source word.
        repeat (10) step();
        check_bit("rst_valid", valid, 1'b0);
        check_word("rst_dout", dout, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_fail", fail, 1'b0);

        data  = '0;
        reset = 1'b0;
        m_last_sent = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_bit("post_rst_valid", valid, 1'b0);
            check_bit("post_rst_busy", busy, 1'b0);
        end

        // Basic transfer: ready on the second valid cycle, response three cycles later.
        data = 32'h2022_0501;
        step();
        check_bit("basic_valid_c1", valid, 1'b1);
        check_word("basic_dout_c1", dout, 32'h2022_0501);
        check_bit("basic_busy_c1", busy, 1'b1);
        step();
        check_bit("basic_valid_c2", valid, 1'b1);
        check_word("basic_dout_c2", dout, 32'h2022_0501);
        accept_and_ack("basic", 3);
        check_word("basic_dout_kept", dout, 32'h2022_0501);
        m_last_sent = 32'h2022_0501;
        for (int i = 0; i < 8; i++) begin
            step();
            check_bit("basic_no_resend", valid, 1'b0);
            check_bit("basic_idle_busy", busy, 1'b0);
        end

        // Back-pressure: 20 cycles without ready while the source drifts.
        data = 32'hA5A5_0F0F;
        step();
        check_bit("bp_valid_first", valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            data = $urandom;
            step();
            check_bit("bp_valid_hold", valid, 1'b1);
            check_word("bp_dout_hold", dout, 32'hA5A5_0F0F);
        end
        data = 32'hA5A5_0F0F;
        accept_and_ack("bp", 2);
        m_last_sent = 32'hA5A5_0F0F;
        step();
        check_bit("bp_no_resend", valid, 1'b0);

        // Source changes 1 -> 2 -> 3 while waiting for the response to 1.
        data = 32'h1;
        step();
        check_word("mid_dout_1", dout, 32'h1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        data = 32'h2;
        step();
        data = 32'h3;
        step();
        check_bit("mid_busy_wait", busy, 1'b1);
        response = 1'b1;
        step();
        response = 1'b0;
        check_bit("mid_busy_resp", busy, 1'b0);
        check_word("mid_dout_kept", dout, 32'h1);
        step();
        check_bit("mid_valid_next", valid, 1'b1);
        check_word("mid_dout_next", dout, 32'h3);
        accept_and_ack("mid", 1);
        m_last_sent = 32'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit("mid_no_more", valid, 1'b0);
        end

`ifdef MASTER_TIMEOUT_EN
        // No response ever: first attempt plus MR retries, each window RT cycles after acceptance.
        data  = 32'h0BAD_F00D;
        ready = 1'b1;
        for (int i = 0; i < (MR + 1) * (RT + 1) + 3; i++) begin
            step();
            check_bit("retry_valid", valid,
                      logic'((i < (MR + 1) * (RT + 1)) && (i % (RT + 1) == 0)));
            check_bit("retry_fail", fail, logic'(i >= (MR + 1) * (RT + 1)));
            check_bit("retry_busy", busy, logic'(i < (MR + 1) * (RT + 1)));
            check_word("retry_dout", dout, 32'h0BAD_F00D);
        end
        ready = 1'b0;
        m_last_sent = 32'h0BAD_F00D;
        data = 32'hDEAD_BEEF;
        step();
        check_bit("after_fail_valid", valid, 1'b1);
        check_bit("fail_sticky", fail, 1'b1);
        accept_and_ack("clear_fail", 0);
        m_last_sent = 32'hDEAD_BEEF;

        // Response arriving on the timeout edge wins.
        data = 32'h7E57_0001;
        step();
        check_bit("edge_valid", valid, 1'b1);
        accept_and_ack("edge", RT - 1);
        m_last_sent = 32'h7E57_0001;
        step();
        check_bit("edge_no_retry", valid, 1'b0);
        check_bit("edge_no_fail", fail, 1'b0);
`else
        // Without the timeout build the master waits for a response indefinitely.
        data = 32'h5555_0000;
        step();
        check_bit("long_valid", valid, 1'b1);
        accept_and_ack("long", 4 * RT);
        m_last_sent = 32'h5555_0000;
        step();
        check_bit("long_no_resend", valid, 1'b0);
        check_bit("long_fail_low", fail, 1'b0);
`endif

        // Reset during SEND abandons the word; it is sent again because last_sent returns to 0.
        data = 32'hCAFE_0001;
        step();
        check_bit("rmid_valid", valid, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_bit("rmid_valid_rst", valid, 1'b0);
        check_word("rmid_dout_rst", dout, '0);
        check_bit("rmid_busy_rst", busy, 1'b0);
        check_bit("rmid_fail_rst", fail, 1'b0);
        step();
        check_bit("rmid_resend_valid", valid, 1'b1);
        check_word("rmid_resend_dout", dout, 32'hCAFE_0001);
        accept_and_ack("rmid", 2);
        m_last_sent = 32'hCAFE_0001;

        // Randomized transfers: random back-pressure, ignored responses in SEND, source drift.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                data = m_last_sent;
            end else if (sel >= 2) begin
                data = $urandom;
            end
            w = data;
            step();
            if (w == m_last_sent) begin
                check_bit("rnd_no_send_valid", valid, 1'b0);
                check_bit("rnd_no_send_busy", busy, 1'b0);
            end else begin
                check_bit("rnd_valid", valid, 1'b1);
                check_word("rnd_dout", dout, w);
                r = $urandom_range(0, 4);
                for (int k = 0; k < r; k++) begin
                    response = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 2) == 0) data = $urandom;
                    step();
                    check_bit("rnd_valid_hold", valid, 1'b1);
                    check_word("rnd_dout_hold", dout, w);
                end
                ready    = 1'b1;
                response = 1'($urandom_range(0, 1));
                step();
                ready    = 1'b0;
                response = 1'b0;
                check_bit("rnd_valid_acc", valid, 1'b0);
                check_bit("rnd_busy_acc", busy, 1'b1);
`ifdef MASTER_TIMEOUT_EN
                d = $urandom_range(0, RT - 1);
`else
                d = $urandom_range(0, 2 * RT);
`endif
                for (int k = 0; k < d; k++) begin
                    if ($urandom_range(0, 2) == 0) data = $urandom;
                    step();
                    check_bit("rnd_valid_wait", valid, 1'b0);
                    check_bit("rnd_busy_wait", busy, 1'b1);
                end
                response = 1'b1;
                step();
                response = 1'b0;
                check_bit("rnd_busy_done", busy, 1'b0);
                check_bit("rnd_fail_done", fail, 1'b0);
                check_word("rnd_dout_done", dout, w);
                m_last_sent = w;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
